rgb_pixel_arbiter: RTL and testbench



---
 rtl/rgb_pixel_arbiter.sv | 150 +++++++++++++++
 tb/tb_rgb_pixel_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pixel_arbiter.sv
// Two-source RGB pixel arbiter with a registered output stage.
// Round-robin between two valid/ready sources. The current owner keeps the
// output for up to MAX_BURST consecutive beats while the other side waits,
// then yields. The output register advances only when it is empty or
// being drained by the downstream consumer.
module rgb_pixel_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] in0_r_i,
    input  logic [7:0] in0_g_i,
    input  logic [7:0] in0_b_i,
    input  logic       in0_valid_i,
    output logic       in0_ready_o,
    input  logic [7:0] in1_r_i,
    input  logic [7:0] in1_g_i,
    input  logic [7:0] in1_b_i,
    input  logic       in1_valid_i,
    output logic       in1_ready_o,
    output logic [7:0] out_r_o,
    output logic [7:0] out_g_o,
    output logic [7:0] out_b_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_src_o
);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]    fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          out_valid_q, out_valid_d;
    pix_t          pix_q, pix_d;
    logic          src_q, src_d;

    pix_t pix0, pix1;
    logic can_load;
    logic burst_done;
    logic grant;
    logic xfer0, xfer1, xfer;
    logic [1:0] own_of_src;

    assign pix0 = '{r: in0_r_i, g: in0_g_i, b: in0_b_i};
    assign pix1 = '{r: in1_r_i, g: in1_g_i, b: in1_b_i};

    // Output slot is free when empty or being consumed this cycle.
    assign can_load   = !out_valid_q || out_ready_i;
    assign burst_done = (cnt_q == CNT_MAX);

    // Grant selection: owner keeps the slot until its burst is spent and
    // the other side is waiting; an idle arbiter favours the source that
    // did not win last.
    always_comb begin
        grant = !last_q;
        case (fsm_q)
            S_IDLE: begin
                if (in0_valid_i && in1_valid_i) grant = !last_q;
                else if (in0_valid_i)           grant = 1'b0;
                else if (in1_valid_i)           grant = 1'b1;
            end
            S_OWN0: begin
                if (in0_valid_i && !(burst_done && in1_valid_i)) grant = 1'b0;
                else if (in1_valid_i)                            grant = 1'b1;
                else                                             grant = 1'b0;
            end
            S_OWN1: begin
                if (in1_valid_i && !(burst_done && in0_valid_i)) grant = 1'b1;
                else if (in0_valid_i)                            grant = 1'b0;
                else                                             grant = 1'b1;
            end
            default: grant = !last_q;
        endcase
    end

    // Readies are held low during reset so no beat is taken in that cycle.
    assign in0_ready_o = !reset_i && can_load && !grant;
    assign in1_ready_o = !reset_i && can_load &&  grant;

    assign xfer0 = in0_valid_i && in0_ready_o;
    assign xfer1 = in1_valid_i && in1_ready_o;
    assign xfer  = xfer0 || xfer1;
    assign own_of_src = xfer1 ? S_OWN1 : S_OWN0;

    // Next-state: load a granted beat, drain to idle, or hold on stall.
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        pix_d       = pix_q;
        src_d       = src_q;
        if (can_load) begin
            if (xfer) begin
                pix_d       = xfer1 ? pix1 : pix0;
                out_valid_d = 1'b1;
                src_d       = xfer1;
                last_d      = xfer1;
                fsm_d       = own_of_src;
                if (fsm_q == own_of_src)
                    cnt_d = burst_done ? cnt_q : cnt_q + CNT_ONE;
                else
                    cnt_d = CNT_ONE;
            end else begin
                out_valid_d = 1'b0;
                fsm_d       = S_IDLE;
                cnt_d       = '0;
            end
        end
    end

    // State and output register; reset discards any held pixel.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            pix_q       <= '0;
            src_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            pix_q       <= pix_d;
            src_q       <= src_d;
        end
    end

    assign out_r_o     = pix_q.r;
    assign out_g_o     = pix_q.g;
    assign out_b_o     = pix_q.b;
    assign out_valid_o = out_valid_q;
    assign out_src_o   = src_q;

endmodule

// File: tb/tb_rgb_pixel_arbiter.sv
// Bench for rgb_pixel_arbiter: two instances (burst 4 and burst 1) share the
// same stimulus; each is checked every cycle against a behavioural model
// that tracks owner / streak / last winner.
module tb_rgb_pixel_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic       v0, v1, ordy;

    logic       rdy0 [2];
    logic       rdy1 [2];
    logic [7:0] o_r  [2];
    logic [7:0] o_g  [2];
    logic [7:0] o_b  [2];
    logic       o_v  [2];
    logic       o_s  [2];

    rgb_pixel_arbiter #(.MAX_BURST(4)) dut_b4 (
        .clk_i(clk), .reset_i(rst),
        .in0_r_i(r0), .in0_g_i(g0), .in0_b_i(b0), .in0_valid_i(v0), .in0_ready_o(rdy0[0]),
        .in1_r_i(r1), .in1_g_i(g1), .in1_b_i(b1), .in1_valid_i(v1), .in1_ready_o(rdy1[0]),
        .out_r_o(o_r[0]), .out_g_o(o_g[0]), .out_b_o(o_b[0]), .out_valid_o(o_v[0]),
        .out_ready_i(ordy), .out_src_o(o_s[0])
    );

    rgb_pixel_arbiter #(.MAX_BURST(1)) dut_b1 (
        .clk_i(clk), .reset_i(rst),
        .in0_r_i(r0), .in0_g_i(g0), .in0_b_i(b0), .in0_valid_i(v0), .in0_ready_o(rdy0[1]),
        .in1_r_i(r1), .in1_g_i(g1), .in1_b_i(b1), .in1_valid_i(v1), .in1_ready_o(rdy1[1]),
        .out_r_o(o_r[1]), .out_g_o(o_g[1]), .out_b_o(o_b[1]), .out_valid_o(o_v[1]),
        .out_ready_i(ordy), .out_src_o(o_s[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model state per instance.
    int         maxb    [2] = '{4, 1};
    int         m_owner [2];   // -1 = nobody holds the output
    int         m_streak[2];
    int         m_last  [2];
    bit         m_ov    [2];
    logic [23:0] m_pix  [2];
    int         m_src   [2];

    // Winner this cycle, or -1 when nobody requests.
    function automatic int pick(input int i);
        if (!v0 && !v1) return -1;
        if (v0 && !v1)  return 0;
        if (!v0 && v1)  return 1;
        if (m_owner[i] >= 0 && m_streak[i] < maxb[i]) return m_owner[i];
        return 1 - m_last[i];
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int  p;
            bit  cl;
            string s;
            p  = pick(i);
            cl = !m_ov[i] || ordy;
            s  = $sformatf("b%0d", maxb[i]);
            if (rst || p >= 0) begin
                chk({s, "_rdy0"}, rdy0[i], (!rst && cl && p == 0));
                chk({s, "_rdy1"}, rdy1[i], (!rst && cl && p == 1));
            end
            chk({s, "_rdy_excl"}, rdy0[i] & rdy1[i], 0);
            chk({s, "_ovalid"}, o_v[i], m_ov[i]);
            if (m_ov[i]) begin
                chk({s, "_opix"}, {o_r[i], o_g[i], o_b[i]}, m_pix[i]);
                chk({s, "_osrc"}, o_s[i], m_src[i]);
            end
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int w;
            w = pick(i);
            if (rst) begin
                m_ov[i] = 0; m_pix[i] = '0; m_src[i] = 0;
                m_owner[i] = -1; m_streak[i] = 0; m_last[i] = 1;
            end else if (!m_ov[i] || ordy) begin
                if (w >= 0) begin
                    m_ov[i]  = 1;
                    m_pix[i] = (w == 0) ? {r0, g0, b0} : {r1, g1, b1};
                    m_src[i] = w;
                    if (m_owner[i] == w)
                        m_streak[i] = (m_streak[i] + 1 > maxb[i]) ? maxb[i] : m_streak[i] + 1;
                    else
                        m_streak[i] = 1;
                    m_owner[i] = w;
                    m_last[i]  = w;
                end else begin
                    m_ov[i] = 0; m_owner[i] = -1; m_streak[i] = 0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit a, input bit b);
        v0 = a; v1 = b;
        r0 = 8'($urandom); g0 = 8'($urandom); b0 = 8'($urandom);
        r1 = 8'($urandom); g1 = 8'($urandom); b1 = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1; m_streak[i] = 0; m_last[i] = 1;
            m_ov[i] = 0; m_pix[i] = '0; m_src[i] = 0;
        end
        rst = 1'b1; ordy = 1'b1;
        drive(1'b0, 1'b0);
        @(posedge clk); #1;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ovalid", o_v[i], 0);
            chk("reset_pix", {o_r[i], o_g[i], o_b[i]}, 0);
            chk("reset_src", o_s[i], 0);
        end
        @(posedge clk); #1;

        // Sole source 0 streams six beats, r = 1..6.
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0);
            r0 = 8'(k);
            cyc();
            chk("solo_r", o_r[0], k);
        end
        drive(1'b0, 1'b0); cyc();

        // Both sources continuously valid, downstream always ready.
        for (int k = 0; k < 20; k++) begin drive(1'b1, 1'b1); cyc(); end
        drive(1'b0, 1'b0); cyc();

        // Stall: source 0 streams, downstream blocks for three cycles.
        for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0); cyc(); end
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0); cyc(); end
        ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b0); cyc(); end
        drive(1'b0, 1'b0); cyc();

        // Source 0 owns for two beats, then drops while source 1 waits.
        drive(1'b1, 1'b0); cyc();
        drive(1'b1, 1'b1); cyc();
        drive(1'b0, 1'b1); cyc();
        chk("handover_src", o_s[0], 1);
        drive(1'b0, 1'b1); cyc();
        drive(1'b0, 1'b0); cyc();

        // Reset while a pixel is held.
        drive(1'b1, 1'b0); r0 = 8'hAA; cyc();
        chk("pre_rst_r", o_r[0], 8'hAA);
        rst = 1'b1; drive(1'b1, 1'b1); cyc();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ovalid", o_v[i], 0);
            chk("rst_r", o_r[i], 0);
        end
        drive(1'b1, 1'b1); cyc();
        for (int i = 0; i < 2; i++) chk("post_rst_src", o_s[i], 0);

        // Randomized traffic with back-pressure and occasional reset.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            ordy = $urandom_range(0, 4) != 0;
            rst  = $urandom_range(0, 199) == 0;
            cyc();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0); ordy = 1'b1;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
